// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side signal bundle for icache_sa.
//   slave  : the cache's view (takes fetch requests and memory data, drives hit/data and read requests)
//   master : the environment's view (datapath fetch port plus memory controller instruction channel)
// Signals:
//   imemREN/imemaddr/iflush -> cache   : fetch request, word-aligned byte address, invalidate-all pulse
//   ihit/imemload           <- cache   : hit this cycle and the fetched word
//   iREN/iaddr              <- cache   : memory read request and address
//   iwait/iload             -> cache   : memory busy flag and read data
interface icache_sa_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_sa.sv
// Set-associative instruction cache with multi-word blocks and LRU replacement.
// Hits are served combinationally in IDLE; a miss fills the whole block word by
// word into the first invalid way (or the LRU way), then passes through DONE.
// Ports:
//   CLK, RST   : clock, asynchronous active-high reset
//   bus        : icache_sa_if.slave (fetch port + memory instruction channel)
//   hit_count, miss_count : saturating statistics, present only when the
//                           macro ICACHE_STATS_EN is defined
module icache_sa #(
  parameter int unsigned SETS          = 8,
  parameter int unsigned WAYS          = 2,
  parameter int unsigned WORDS_PER_BLK = 2
) (
  input  logic         CLK,
  input  logic         RST,
  icache_sa_if.slave   bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int unsigned OFF_W     = $clog2(WORDS_PER_BLK);
  localparam int unsigned CNT_W     = (OFF_W > 0) ? OFF_W : 1;
  localparam int unsigned IDX_W     = $clog2(SETS);
  localparam int unsigned TAG_LSB   = 2 + OFF_W + IDX_W;
  localparam int unsigned TAG_W     = 32 - TAG_LSB;
  localparam int unsigned WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned LAST_WORD = WORDS_PER_BLK - 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t r_state;
  state_t w_next_state;

  logic [WAYS-1:0]  r_valid [SETS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [31:0]      r_data  [SETS][WAYS][WORDS_PER_BLK];

  logic [31:0]      r_base;
  logic [WAY_W-1:0] r_victim;
  logic [CNT_W-1:0] r_cnt;

  logic [CNT_W-1:0] w_word;
  logic [IDX_W-1:0] w_index;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_fill_index;
  logic [TAG_W-1:0] w_fill_tag;

  logic             w_hit_any;
  logic [WAY_W-1:0] w_hit_way;
  logic             w_ihit;
  logic             w_miss;
  logic             w_fill_beat;
  logic             w_fill_done;
  logic [WAY_W-1:0] w_victim;
  logic [WAY_W-1:0] w_age [WAYS];

  logic             w_touch_en;
  logic [IDX_W-1:0] w_touch_set;
  logic [WAY_W-1:0] w_touch_way;

  // Address split for the live request and for the latched fill block
  assign w_word       = CNT_W'((bus.imemaddr >> 2) & 32'(LAST_WORD));
  assign w_index      = IDX_W'(bus.imemaddr >> (2 + OFF_W));
  assign w_tag        = TAG_W'(bus.imemaddr >> TAG_LSB);
  assign w_fill_index = IDX_W'(r_base >> (2 + OFF_W));
  assign w_fill_tag   = TAG_W'(r_base >> TAG_LSB);

  // Tag lookup across all ways of the indexed set
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit_any && r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
        w_hit_any = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // A flush in the same cycle suppresses both the hit and the miss
  assign w_ihit      = (r_state == S_IDLE) && bus.imemREN && !bus.iflush && w_hit_any;
  assign w_miss      = (r_state == S_IDLE) && bus.imemREN && !bus.iflush && !w_hit_any;
  assign w_fill_beat = (r_state == S_FILL) && !bus.iflush && !bus.iwait;
  assign w_fill_done = w_fill_beat && (r_cnt == CNT_W'(LAST_WORD));

  // Victim: lowest-numbered invalid way, otherwise the oldest way
  always_comb begin
    logic found;
    found    = 1'b0;
    w_victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !r_valid[w_index][w]) begin
        found    = 1'b1;
        w_victim = WAY_W'(w);
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (w_age[w] == WAY_W'(WAYS - 1)) w_victim = WAY_W'(w);
      end
    end
  end

  // Way to promote to MRU: the hit way in IDLE, or the victim on fill completion
  always_comb begin
    w_touch_en  = 1'b0;
    w_touch_set = w_index;
    w_touch_way = w_hit_way;
    if (w_ihit) begin
      w_touch_en = 1'b1;
    end else if (w_fill_done) begin
      w_touch_en  = 1'b1;
      w_touch_set = w_fill_index;
      w_touch_way = r_victim;
    end
  end

  // LRU ages: a permutation per set, 0 = MRU; absent for direct-mapped
  generate
    if (WAYS > 1) begin : g_lru
      logic [WAY_W-1:0] r_age [SETS][WAYS];

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              r_age[s][w] <= WAY_W'(w);
        end else if (bus.iflush) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              r_age[s][w] <= WAY_W'(w);
        end else if (w_touch_en) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == w_touch_way)
              r_age[w_touch_set][w] <= '0;
            else if (r_age[w_touch_set][w] < r_age[w_touch_set][w_touch_way])
              r_age[w_touch_set][w] <= r_age[w_touch_set][w] + WAY_W'(1);
          end
        end
      end

      always_comb begin
        for (int w = 0; w < WAYS; w++) w_age[w] = r_age[w_index][w];
      end
    end else begin : g_no_lru
      always_comb w_age[0] = '0;
    end
  endgenerate

  // Storage, fill address and fill counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w] <= '0;
          for (int k = 0; k < WORDS_PER_BLK; k++) r_data[s][w][k] <= '0;
        end
      end
      r_base   <= '0;
      r_victim <= '0;
      r_cnt    <= '0;
    end else begin
      if (bus.iflush) begin
        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
      end
      if (w_miss) begin
        r_base   <= bus.imemaddr & ~(32'(4 * WORDS_PER_BLK) - 32'd1);
        r_victim <= w_victim;
        r_cnt    <= '0;
      end
      if (w_fill_beat) begin
        r_data[w_fill_index][r_victim][r_cnt] <= bus.iload;
        if (w_fill_done) begin
          r_cnt                          <= '0;
          r_valid[w_fill_index][r_victim] <= 1'b1;
          r_tag[w_fill_index][r_victim]   <= w_fill_tag;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_miss) w_next_state = S_FILL;
      S_FILL: begin
        if (bus.iflush)       w_next_state = S_IDLE;
        else if (w_fill_done) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.ihit     = w_ihit;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    if (w_ihit) bus.imemload = r_data[w_index][w_hit_way][w_word];
    if (r_state == S_FILL) begin
      bus.iREN  = 1'b1;
      bus.iaddr = r_base + (32'(r_cnt) << 2);
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Saturating statistics, untouched by flush
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_ihit && (r_hit_count != 32'hFFFF_FFFF))  r_hit_count  <= r_hit_count + 32'd1;
      if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule
